zigzag_buffer_8x8: RTL and testbench

//  Ping-pong reorder buffer directly downstream of the float-to-int8 quantiser stage.
//  - Input: one signed int8 coefficient per din_valid, raster order within an 8x8 block.
//  - Output: each complete 64-coefficient block re-emitted in JPEG zigzag order.
//  - Uses a valid/ready handshake so the entropy coder can apply backpressure.
//  - The upstream stage has no ready; samples arriving with no free bank are dropped and flagged.

---
 rtl/zigzag_buffer_8x8.sv | 111 +++++++++++
 tb/tb_zigzag_buffer_8x8.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/zigzag_buffer_8x8.sv
// Ping-pong 2x64 reorder buffer: raster-order int8 coefficients in, each complete
// 8x8 block out in JPEG zigzag order (or raster order when ZIGZAG_EN = 0).
module zigzag_buffer_8x8 #(
  parameter int DW        = 8,
  parameter bit ZIGZAG_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          overflow
);

  // Raster index read at each zigzag position k.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [DW-1:0] mem_q [2][64];
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic [5:0]    wr_idx_q, wr_idx_d;
  logic          rd_bank_q, rd_bank_d;
  logic [5:0]    rd_idx_q, rd_idx_d;
  logic          overflow_q, overflow_d;
  logic          wr_en_s;
  logic          rd_xfer_s;
  logic [5:0]    rd_addr_s;

  // Next-state for both pointers; a completing write and a completing read never
  // target the same bank because one needs it empty and the other needs it full.
  always_comb begin
    wr_en_s    = din_valid & ~full_q[wr_bank_q];
    rd_xfer_s  = full_q[rd_bank_q] & dout_ready;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    wr_idx_d   = wr_idx_q;
    rd_bank_d  = rd_bank_q;
    rd_idx_d   = rd_idx_q;
    overflow_d = overflow_q;
    if (wr_en_s) begin
      wr_idx_d = wr_idx_q + 6'd1;
      if (wr_idx_q == 6'd63) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_bank_d = wr_bank_q;
      end
    end else if (din_valid) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
    if (rd_xfer_s) begin
      rd_idx_d = rd_idx_q + 6'd1;
      if (rd_idx_q == 6'd63) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_bank_d = rd_bank_q;
      end
    end else begin
      rd_idx_d = rd_idx_q;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= 2'b00;
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= 6'd0;
      rd_bank_q  <= 1'b0;
      rd_idx_q   <= 6'd0;
      overflow_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      wr_idx_q   <= wr_idx_d;
      rd_bank_q  <= rd_bank_d;
      rd_idx_q   <= rd_idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Bank storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem_q[wr_bank_q][wr_idx_q] <= din;
    end
  end

  assign rd_addr_s  = ZIGZAG_EN ? ZZ[rd_idx_q] : rd_idx_q;
  assign dout_valid = full_q[rd_bank_q];
  // Gating with the full flag keeps dout at zero out of reset and between blocks.
  assign dout       = full_q[rd_bank_q] ? mem_q[rd_bank_q][rd_addr_s] : {DW{1'b0}};
  assign dout_last  = full_q[rd_bank_q] & (rd_idx_q == 6'd63);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_zigzag_buffer_8x8.sv
// Scoreboard bench: a zigzag instance and a raster-bypass instance share one stimulus
// stream; expected outputs are queued at write time and popped on each transfer.
module tb_zigzag_buffer_8x8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, din_valid, dout_ready;
  logic [DW-1:0] din;
  logic [DW-1:0] dout_zz, dout_rw;
  logic          v_zz, v_rw, l_zz, l_rw, o_zz, o_rw;

  always #5 clk = ~clk;

  zigzag_buffer_8x8 #(.DW(DW), .ZIGZAG_EN(1'b1)) u_zz (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .dout(dout_zz), .dout_valid(v_zz), .dout_ready(dout_ready),
    .dout_last(l_zz), .overflow(o_zz)
  );

  zigzag_buffer_8x8 #(.DW(DW), .ZIGZAG_EN(1'b0)) u_rw (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .dout(dout_rw), .dout_valid(v_rw), .dout_ready(dout_ready),
    .dout_last(l_rw), .overflow(o_rw)
  );

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            xfer_cnt;
  int            t_first;
  int            t_last;
  int            zz_tab [64];
  logic [DW:0]   q_zz [$];
  logic [DW:0]   q_rw [$];
  logic [DW-1:0] blk [64];
  logic          stall_q = 1'b0;
  logic [DW-1:0] held;
  logic          held_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent zigzag model: walk anti-diagonals, alternating direction.
  task automatic build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin zz_tab[k] = 8 * r + (s - r); k++; end
      end else begin
        for (int r = hi; r >= lo; r--) begin zz_tab[k] = 8 * r + (s - r); k++; end
      end
    end
  endtask

  task automatic push_blk();
    for (int k = 0; k < 64; k++) begin
      q_zz.push_back({k == 63, blk[zz_tab[k]]});
      q_rw.push_back({k == 63, blk[k]});
    end
  endtask

  // One clock: check transfers/holds on the negedge, return #1 after the posedge.
  task automatic tick();
    logic [DW:0] e;
    @(negedge clk);
    if (stall_q && v_zz === 1'b1) begin
      chk("hold_data", {24'd0, dout_zz}, {24'd0, held});
      chk("hold_last", {31'd0, l_zz}, {31'd0, held_last});
    end
    stall_q   = (v_zz === 1'b1) && (dout_ready === 1'b0);
    held      = dout_zz;
    held_last = l_zz;
    if (v_zz === 1'b1 && dout_ready === 1'b1) begin
      chk("zz_unexpected_out", {31'd0, q_zz.size() > 0}, 32'd1);
      if (q_zz.size() > 0) begin
        e = q_zz.pop_front();
        chk("zz_data", {24'd0, dout_zz}, {24'd0, e[DW-1:0]});
        chk("zz_last", {31'd0, l_zz}, {31'd0, e[DW]});
      end
      if (t_first < 0) t_first = cyc;
      t_last = cyc;
      xfer_cnt++;
    end
    if (v_rw === 1'b1 && dout_ready === 1'b1) begin
      chk("rw_unexpected_out", {31'd0, q_rw.size() > 0}, 32'd1);
      if (q_rw.size() > 0) begin
        e = q_rw.pop_front();
        chk("rw_data", {24'd0, dout_rw}, {24'd0, e[DW-1:0]});
        chk("rw_last", {31'd0, l_rw}, {31'd0, e[DW]});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic write_blk(input string tag);
    for (int i = 0; i < 64; i++) begin
      din       = blk[i];
      din_valid = 1'b1;
      tick();
      chk(tag, {31'd0, v_zz}, {31'd0, i == 63});
    end
    din_valid = 1'b0;
  endtask

  task automatic drain(input int budget, input bit rand_ready);
    for (int n = 0; n < budget && q_zz.size() > 0; n++) begin
      dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    dout_ready = 1'b1;
    chk("drain_zz_empty", q_zz.size(), 32'd0);
    chk("drain_rw_empty", q_rw.size(), 32'd0);
  endtask

  initial begin
    build_zz();
    rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0; din = 8'h00;
    xfer_cnt = 0; t_first = -1; t_last = -1;

    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", {31'd0, v_zz}, 32'd0);
    chk("rst_dout", {24'd0, dout_zz}, 32'd0);
    chk("rst_last", {31'd0, l_zz}, 32'd0);
    chk("rst_overflow", {31'd0, o_zz}, 32'd0);

    // Ramp with ready held high.
    dout_ready = 1'b1;
    for (int i = 0; i < 64; i++) blk[i] = 8'(i);
    push_blk();
    write_blk("ramp_latency");
    drain(200, 1'b0);

    // Same ramp, random backpressure on the drain.
    for (int i = 0; i < 64; i++) blk[i] = 8'(i + 100);
    push_blk();
    write_blk("bp_latency");
    xfer_cnt = 0;
    drain(1000, 1'b1);
    chk("bp_xfer_count", xfer_cnt, 32'd64);

    // Three blocks streamed back to back.
    xfer_cnt = 0; t_first = -1; t_last = -1;
    dout_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 64; i++) blk[i] = 8'($urandom_range(0, 255));
      push_blk();
      for (int i = 0; i < 64; i++) begin
        din = blk[i]; din_valid = 1'b1;
        tick();
      end
    end
    din_valid = 1'b0;
    drain(200, 1'b0);
    chk("stream_xfer_count", xfer_cnt, 32'd192);
    chk("stream_gapless", t_last - t_first, 32'd191);
    chk("stream_overflow", {31'd0, o_zz}, 32'd0);

    // Fill both banks with no reader, then one extra sample must drop.
    dout_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 64; i++) blk[i] = 8'(b * 64 + i + 7);
      push_blk();
      for (int i = 0; i < 64; i++) begin
        din = blk[i]; din_valid = 1'b1;
        tick();
      end
    end
    din_valid = 1'b0;
    chk("ovf_not_yet", {31'd0, o_zz}, 32'd0);
    din = 8'h55; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("ovf_set", {31'd0, o_zz}, 32'd1);
    chk("ovf_set_raw", {31'd0, o_rw}, 32'd1);
    tick();
    drain(400, 1'b0);
    chk("ovf_sticky", {31'd0, o_zz}, 32'd1);

    // Reset in the middle of a block discards the partial write and the sticky flag.
    for (int i = 0; i < 30; i++) begin
      din = 8'(200 + i); din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_overflow", {31'd0, o_zz}, 32'd0);
    chk("mid_rst_valid", {31'd0, v_zz}, 32'd0);
    for (int i = 0; i < 64; i++) blk[i] = 8'(63 - i);
    push_blk();
    write_blk("mid_rst_latency");
    drain(200, 1'b0);

    // Signed extremes pass through bit-exact.
    for (int i = 0; i < 64; i++) blk[i] = (i % 2 == 0) ? 8'h80 : 8'h7F;
    push_blk();
    write_blk("signed_latency");
    drain(200, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
